// File: rtl/uart_tx.sv
// UART transmitter: 16 clk cycles per bit, LSB-first frame of start, data,
// optional parity and 1-2 stop bits, with a valid/ready byte handshake.
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 ready_out,
  output logic                 tx,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [5:0]           led
);

  localparam int BW = $clog2(DATA_BITS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 tx_q, tx_d;
  logic                 busy_q;
  logic                 done_q, done_d;
  logic [5:0]           led_q, led_d;
  logic                 bit_end;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 2) ? ^d : ~^d;
  endfunction

  // LEDs show the low six data bits inverted; bits beyond DATA_BITS stay dark.
  function automatic logic [5:0] led_of(input logic [DATA_BITS-1:0] d);
    logic [5:0] r;
    r = 6'b111111;
    for (int i = 0; i < 6; i++)
      if (i < DATA_BITS) r[i] = ~d[i];
    return r;
  endfunction

  assign bit_end   = (cnt_q == 4'hF);
  assign ready_out = (state_q == S_IDLE) && !rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 4'd1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    led_d   = led_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 4'd0;
        tx_d  = 1'b1;
        if (valid_in) begin
          state_d = S_START;
          shreg_d = data_in;
          data_d  = data_in;
          led_d   = led_of(data_in);
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PAR;
              tx_d    = parity_bit(data_q);
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == BW'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            bit_d   = '0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      led_q   <= 6'b111111;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
      led_q   <= led_d;
    end
  end

  assign tx       = tx_q;
  assign busy_out = busy_q;
  assign done_out = done_q;
  assign led      = led_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (8N1, 8E1, 8O2) share stimulus and are
// compared every cycle against a frame-level reference model.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic [7:0] data_in;

  logic [2:0] tx_w, busy_w, done_w, rdy_w;
  logic [5:0] led_w [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(0)) u_n1 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .ready_out(rdy_w[0]), .tx(tx_w[0]), .busy_out(busy_w[0]),
    .done_out(done_w[0]), .led(led_w[0]));

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(2)) u_e1 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .ready_out(rdy_w[1]), .tx(tx_w[1]), .busy_out(busy_w[1]),
    .done_out(done_w[1]), .led(led_w[1]));

  uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .PARITY(1)) u_o2 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .ready_out(rdy_w[2]), .tx(tx_w[2]), .busy_out(busy_w[2]),
    .done_out(done_w[2]), .led(led_w[2]));

  // Reference model: each frame is a list of bits, each held for 16 cycles.
  bit         idle_m  [3];
  int         pos_m   [3];
  int         flen_m  [3];
  logic [11:0] fr_m   [3];
  logic       exp_tx  [3];
  logic       exp_busy[3];
  logic       exp_done[3];
  logic [5:0] exp_led [3];
  logic       done0_smp;

  function automatic int pmode(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 1);
  endfunction

  function automatic int nstop(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    idle_m[k]   = 1'b1;
    pos_m[k]    = 0;
    flen_m[k]   = 0;
    fr_m[k]     = '0;
    exp_tx[k]   = 1'b1;
    exp_busy[k] = 1'b0;
    exp_done[k] = 1'b0;
    exp_led[k]  = 6'b111111;
  endtask

  task automatic model_step(input int k, input logic r, input logic v, input logic [7:0] d);
    int nb;
    if (r) begin
      model_reset(k);
    end else if (idle_m[k] && v) begin
      fr_m[k] = '0;
      for (int i = 0; i < 8; i++) fr_m[k][1+i] = d[i];
      nb = 9;
      if (pmode(k) != 0) begin
        fr_m[k][nb] = (pmode(k) == 2) ? ^d : ~^d;
        nb++;
      end
      for (int s = 0; s < nstop(k); s++) begin
        fr_m[k][nb] = 1'b1;
        nb++;
      end
      flen_m[k]   = 16 * nb;
      pos_m[k]    = 0;
      idle_m[k]   = 1'b0;
      exp_tx[k]   = fr_m[k][0];
      exp_busy[k] = 1'b1;
      exp_done[k] = 1'b0;
      exp_led[k]  = ~d[5:0];
    end else if (!idle_m[k]) begin
      pos_m[k]++;
      exp_done[k] = 1'b0;
      if (pos_m[k] == flen_m[k]) begin
        idle_m[k]   = 1'b1;
        exp_tx[k]   = 1'b1;
        exp_busy[k] = 1'b0;
        exp_done[k] = 1'b1;
      end else begin
        exp_tx[k] = fr_m[k][pos_m[k] / 16];
      end
    end else begin
      exp_done[k] = 1'b0;
    end
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance the model.
  task automatic cycle(input logic r, input logic v, input logic [7:0] d);
    rst      = r;
    valid_in = v;
    data_in  = d;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("tx%0d", k),    32'(tx_w[k]),   32'(exp_tx[k]));
      check($sformatf("busy%0d", k),  32'(busy_w[k]), 32'(exp_busy[k]));
      check($sformatf("done%0d", k),  32'(done_w[k]), 32'(exp_done[k]));
      check($sformatf("ready%0d", k), 32'(rdy_w[k]),  32'(idle_m[k] && !r));
      check($sformatf("led%0d", k),   32'(led_w[k]),  32'(exp_led[k]));
    end
    done0_smp = done_w[0];
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k, r, v, d);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    for (int k = 0; k < 3; k++) model_reset(k);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00);
    idle(2);

    // 0xA5: done pulse latency measured from the handshake cycle
    cycle(1'b0, 1'b1, 8'hA5);
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      if (done0_smp) begin
        n = i;
        break;
      end
    end
    check("a5_done_latency", 32'(n), 32'd161);
    idle(60);

    // back-to-back 0x00 then 0xFF with valid held
    cycle(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 200; i++) cycle(1'b0, 1'b1, 8'hFF);
    idle(220);

    // 0x81 frame with an ignored 0x3C request at T+50
    cycle(1'b0, 1'b1, 8'h81);
    idle(49);
    cycle(1'b0, 1'b1, 8'h3C);
    idle(160);

    // parity slot check with 0x07
    cycle(1'b0, 1'b1, 8'h07);
    idle(200);

    // reset at T+40 of a 0x55 frame, then 0x12
    cycle(1'b0, 1'b1, 8'h55);
    idle(39);
    cycle(1'b1, 1'b0, 8'h00);
    idle(3);
    cycle(1'b0, 1'b1, 8'h12);
    idle(200);

    // randomized traffic with occasional resets and held requests
    for (int i = 0; i < 5000; i++) begin
      logic r, v;
      logic [7:0] d;
      r = ($urandom_range(0, 699) == 0);
      v = ($urandom_range(0, 3) == 0);
      d = 8'($urandom);
      cycle(r, v, d);
    end
    idle(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 Parameter STOP_BITS, default 1, number of stop bits (1 or 2).
REQ-003 Parameter PARITY, default 0, parity mode: 0 = none, 1 = odd, 2 = even.
REQ-004 One clock and one reset; reset is synchronous and active-high.
REQ-005 clk  input  1  system clock, 16 clk cycles per bit period (16x baud, same timing base as the UART receiver).
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 valid_in  input  1  data_in holds a byte to transmit.
REQ-008 data_in  input  DATA_BITS  byte to transmit.
REQ-009 ready_out  output  1  transmitter accepts data this cycle.
REQ-010 tx  output  1  serial line, idle high.
REQ-011 busy_out  output  1  frame in progress.
REQ-012 done_out  output  1  one-cycle pulse at frame completion.
REQ-013 led  output  6  ~latched_data[5:0], for the board LEDs.

Function
REQ-014 States: IDLE, START, DATA, PAR, STOP; a 4-bit clk counter (0..15) and a bit counter sized for DATA_BITS.
REQ-015 ready_out = (state == IDLE) && !rst, combinational; all other outputs registered.
REQ-016 Handshake: transfer occurs on a rising edge where valid_in && ready_out; data_in is latched into a shift register, and the FSM goes to START with the clk counter at 0.
REQ-017 valid_in while not ready_out is ignored; data_in is not sampled and no error is raised.
REQ-018 With handshake in cycle T, tx = 0 for cycles T+1 .. T+16 (start bit).
REQ-019 DATA: LSB first; bit i is driven for cycles T+17+16i .. T+32+16i; the shift register shifts right each 16 cycles.
REQ-020 PAR (only if PARITY != 0): one bit period after the data bits; even = XOR of data bits, odd = inverted XOR; PARITY = 0 skips PAR entirely.
REQ-021 STOP: tx = 1 for 16*STOP_BITS cycles, then the FSM returns to IDLE.
REQ-022 Frame length = 16*(1 + DATA_BITS + (PARITY != 0) + STOP_BITS) cycles: 160 for 8N1, 176 for 8E1.
REQ-023 done_out = 1 for exactly the first cycle back in IDLE after STOP; otherwise 0.
REQ-024 busy_out = 1 in START, DATA, PAR, STOP; 0 in IDLE.
REQ-025 Back-to-back: with valid_in held high, the next handshake occurs in that first IDLE cycle, so the frame period is 161 cycles for 8N1 and tx stays high for exactly that one cycle between frames.
REQ-026 tx is glitch-free: driven from a register, changing only at bit-period boundaries.
REQ-027 The clk counter wraps 15 -> 0 at each bit boundary; the bit counter resets to 0 on entry to DATA.
REQ-028 The latched data register (and led) holds its value after the frame until the next handshake.

Reset
REQ-029 rst high on an edge forces, on the next cycle: state IDLE, tx = 1, busy_out = 0, done_out = 0, counters 0, latched data 0 (led = 6'b111111).
REQ-030 ready_out = 0 while rst is high; no handshake is accepted in a reset cycle.
REQ-031 rst mid-frame aborts the frame immediately: tx returns high on the next cycle, no done_out pulse, and the aborted byte is not resumed.
REQ-032 After rst deasserts, ready_out = 1 in the first cycle.

Verification
REQ-033 Reset: hold rst 3 cycles, release -> tx = 1, ready_out = 1, busy_out = 0, done_out = 0, led = 6'b111111.
REQ-034 8N1, send 0xA5 at T -> tx per 16-cycle slot: 0,1,0,1,0,0,1,0,1,1; done_out pulses at T+161; the looped-back uart_rx produces data_out = 0xA5.
REQ-035 Back-to-back 0x00 then 0xFF with valid_in held -> second start bit begins at T+162; exactly one idle-high cycle between frames.
REQ-036 valid_in pulsed with 0x3C at T+50 during a 0x81 frame -> ignored; transmitted frame is 0x81 only, ready_out stays 0.
REQ-037 PARITY = 2 send 0x07 -> parity slot tx = 1, frame 176 cycles; PARITY = 1 send 0x07 -> parity slot tx = 0.
REQ-038 rst asserted at T+40 of a 0x55 frame -> tx = 1 from T+41, no done_out pulse, new 0x12 frame transmits correctly after release.
